// File: rtl/register_file.sv
// Two-read, one-write register file for the single-cycle datapath.
// Combinational reads, edge-triggered write, r0 hardwired to zero.

module register_file_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (!reset_n)
            q <= '0;
        else if (we)
            q <= wdata;
    end
endmodule

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] Read1,
    input  logic [ADDR_WIDTH-1:0] Read2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] Data1,
    output logic [DATA_WIDTH-1:0] Data2
);
    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    wr_req_t                             wr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]    rf;

    assign wr = '{en: RegWrite, addr: WriteReg, data: WriteData};

    // r0 has no storage, so it reads zero even before the first reset.
    assign rf[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        register_file_entry #(.DATA_WIDTH(DATA_WIDTH)) u_entry (
            .clock   (clock),
            .reset_n (reset_n),
            .we      (wr.en && (wr.addr == ADDR_WIDTH'(i))),
            .wdata   (wr.data),
            .q       (rf[i])
        );
    end

    assign Data1 = rf[Read1];
    assign Data2 = rf[Read2];
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.

module tb_register_file;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [5:0]  Read1, Read2, WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] Data1, Data2;

    int checks = 0;
    int errors = 0;

    register_file dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .Read1     (Read1),
        .Read2     (Read2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Data1     (Data1),
        .Data2     (Data2)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_r0_before_reset();
        Read1 = 6'd0; Read2 = 6'd0;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL r0_pre_reset_d1: got %h want %h", Data1, 32'h0);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL r0_pre_reset_d2: got %h want %h", Data2, 32'h0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; RegWrite = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 64; a++) begin
            Read1 = 6'(a); Read2 = 6'(63 - a);
            #1;
            checks++;
            if (Data1 !== 32'h0) begin
                errors++; $display("FAIL reset_d1[%0d]: got %h want %h", a, Data1, 32'h0);
            end
            checks++;
            if (Data2 !== 32'h0) begin
                errors++; $display("FAIL reset_d2[%0d]: got %h want %h", 63 - a, Data2, 32'h0);
            end
        end
    endtask

    task automatic test_basic_write();
        WriteReg = 6'd3; WriteData = 32'hABCDEFFF; RegWrite = 1'b1;
        Read1 = 6'd3; Read2 = 6'd5;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL no_bypass: got %h want %h", Data1, 32'h0);
        end
        tick();
        RegWrite = 1'b0;
        checks++;
        if (Data1 !== 32'hABCDEFFF) begin
            errors++; $display("FAIL basic_write_d1: got %h want %h", Data1, 32'hABCDEFFF);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL basic_write_d2: got %h want %h", Data2, 32'h0);
        end
    endtask

    task automatic test_write_disable();
        RegWrite = 1'b0; WriteReg = 6'd3; WriteData = 32'h12345678; Read1 = 6'd3;
        tick();
        checks++;
        if (Data1 !== 32'hABCDEFFF) begin
            errors++; $display("FAIL write_disable_r3: got %h want %h", Data1, 32'hABCDEFFF);
        end
        Read1 = 6'd7; Read2 = 6'd10;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL write_disable_r7: got %h want %h", Data1, 32'h0);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL write_disable_r10: got %h want %h", Data2, 32'h0);
        end
    endtask

    task automatic test_r0_hardwired();
        RegWrite = 1'b1; WriteReg = 6'd0; WriteData = 32'hFFFFFFFF;
        tick();
        RegWrite = 1'b0; Read1 = 6'd0; Read2 = 6'd0;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL r0_write_d1: got %h want %h", Data1, 32'h0);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL r0_write_d2: got %h want %h", Data2, 32'h0);
        end
    endtask

    task automatic test_full_range();
        RegWrite = 1'b1; WriteReg = 6'd63; WriteData = 32'hDEADBEEF;
        tick();
        WriteReg = 6'd32; WriteData = 32'h00000001;
        tick();
        RegWrite = 1'b0; Read1 = 6'd63; Read2 = 6'd32;
        #1;
        checks++;
        if (Data1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL range_r63: got %h want %h", Data1, 32'hDEADBEEF);
        end
        checks++;
        if (Data2 !== 32'h00000001) begin
            errors++; $display("FAIL range_r32: got %h want %h", Data2, 32'h00000001);
        end
        Read1 = 6'd31; Read2 = 6'd1;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL range_r31_alias: got %h want %h", Data1, 32'h0);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL range_r1_alias: got %h want %h", Data2, 32'h0);
        end
        Read1 = 6'd63; Read2 = 6'd63;
        #1;
        checks++;
        if (Data1 !== 32'hDEADBEEF || Data2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL same_addr_reads: got %h/%h want %h", Data1, Data2, 32'hDEADBEEF);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [5];
        vals = '{32'h11111111, 32'h22222222, 32'h0F0F0F0F, 32'h80000000, 32'h00000005};
        RegWrite = 1'b1;
        for (int i = 0; i < 5; i++) begin
            WriteReg = 6'(i + 10); WriteData = vals[i];
            tick();
        end
        RegWrite = 1'b0;
        for (int i = 0; i < 5; i++) begin
            Read1 = 6'(i + 10); Read2 = 6'(14 - i);
            #1;
            checks++;
            if (Data1 !== vals[i]) begin
                errors++; $display("FAIL b2b_d1[%0d]: got %h want %h", i + 10, Data1, vals[i]);
            end
            checks++;
            if (Data2 !== vals[4 - i]) begin
                errors++; $display("FAIL b2b_d2[%0d]: got %h want %h", 14 - i, Data2, vals[4 - i]);
            end
        end
    endtask

    task automatic test_overwrite();
        // r3 holds ABCDEFFF; old value stays visible until the edge
        RegWrite = 1'b1; WriteReg = 6'd3; WriteData = 32'hCAFEF00D;
        Read1 = 6'd3; Read2 = 6'd3;
        #1;
        checks++;
        if (Data1 !== 32'hABCDEFFF) begin
            errors++; $display("FAIL overwrite_before: got %h want %h", Data1, 32'hABCDEFFF);
        end
        tick();
        RegWrite = 1'b0;
        checks++;
        if (Data2 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL overwrite_after: got %h want %h", Data2, 32'hCAFEF00D);
        end
    endtask

    task automatic test_reset_priority();
        reset_n = 1'b0; RegWrite = 1'b1; WriteReg = 6'd4; WriteData = 32'h55555555;
        Read1 = 6'd3; Read2 = 6'd4;
        tick();
        reset_n = 1'b1; RegWrite = 1'b0;
        #1;
        checks++;
        if (Data1 !== 32'h0) begin
            errors++; $display("FAIL rst_prio_r3: got %h want %h", Data1, 32'h0);
        end
        checks++;
        if (Data2 !== 32'h0) begin
            errors++; $display("FAIL rst_prio_r4: got %h want %h", Data2, 32'h0);
        end
        Read1 = 6'd63; Read2 = 6'd12;
        #1;
        checks++;
        if (Data1 !== 32'h0 || Data2 !== 32'h0) begin
            errors++; $display("FAIL rst_prio_others: got %h/%h want %h", Data1, Data2, 32'h0);
        end
        // writes resume on the first edge with reset released
        RegWrite = 1'b1; WriteReg = 6'd4; WriteData = 32'h13579BDF; Read1 = 6'd4;
        tick();
        RegWrite = 1'b0;
        checks++;
        if (Data1 !== 32'h13579BDF) begin
            errors++; $display("FAIL post_reset_write: got %h want %h", Data1, 32'h13579BDF);
        end
    endtask

    initial begin
        reset_n = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
        Read1 = '0; Read2 = '0;
        test_r0_before_reset();
        @(posedge clock); #1;
        test_reset();
        test_basic_write();
        test_write_disable();
        test_r0_hardwired();
        test_full_range();
        test_back_to_back();
        test_overwrite();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
